// File: rtl/foxtrot_pkg.sv
// Shared definitions for the rename / reorder-buffer slice.
package foxtrot_pkg;

  localparam int unsigned INVALID_LRN          = 62;
  localparam int unsigned ZERO_LRN             = 63;
  localparam int unsigned DEFAULT_PRN_BITS     = 6;
  localparam int unsigned DEFAULT_MAX_OPERANDS = 3;

  typedef struct packed {
    logic                                                  valid;
    logic                                                  done;
    logic [DEFAULT_MAX_OPERANDS-1:0]                       old_valid;
    logic [DEFAULT_MAX_OPERANDS-1:0][DEFAULT_PRN_BITS-1:0] old_prn;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks up to two in-order retirements from the head pair and builds the free vectors.
module rob_retire_select
  import foxtrot_pkg::*;
#(
  parameter int unsigned PRN_BITS     = DEFAULT_PRN_BITS,
  parameter int unsigned MAX_OPERANDS = DEFAULT_MAX_OPERANDS
) (
  input  rob_entry_t          head_entry,
  input  rob_entry_t          next_entry,
  output logic                r0,
  output logic                r1,
  output logic                next_free_valid [MAX_OPERANDS*2],
  output logic [PRN_BITS-1:0] next_free_prns  [MAX_OPERANDS*2]
);

  always_comb begin
    r0 = head_entry.valid && head_entry.done;
    r1 = r0 && next_entry.valid && next_entry.done;
    for (int i = 0; i < int'(MAX_OPERANDS * 2); i++) begin
      next_free_valid[i] = 1'b0;
      next_free_prns[i]  = '0;
    end
    for (int j = 0; j < int'(MAX_OPERANDS); j++) begin
      next_free_valid[j] = r0 && head_entry.old_valid[j];
      if (next_free_valid[j]) next_free_prns[j] = PRN_BITS'(head_entry.old_prn[j]);
      next_free_valid[MAX_OPERANDS + j] = r1 && next_entry.old_valid[j];
      if (next_free_valid[MAX_OPERANDS + j])
        next_free_prns[MAX_OPERANDS + j] = PRN_BITS'(next_entry.old_prn[j]);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer; returns superseded PRNs to rename, up to two entries per cycle.
module reorder_buffer
  import foxtrot_pkg::*;
#(
  parameter int unsigned PRN_BITS     = DEFAULT_PRN_BITS,
  parameter int unsigned MAX_OPERANDS = DEFAULT_MAX_OPERANDS,
  parameter int unsigned ROB_ENTRIES  = 16,
  localparam int unsigned TAG_BITS    = $clog2(ROB_ENTRIES),
  localparam int unsigned CNT_BITS    = TAG_BITS + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic                alloc_old_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0] alloc_old_prn   [MAX_OPERANDS],
  output logic                alloc_ready,
  output logic [TAG_BITS-1:0] alloc_tag,
  input  logic                complete_valid,
  input  logic [TAG_BITS-1:0] complete_tag,
  output logic                free_valid [MAX_OPERANDS*2],
  output logic [PRN_BITS-1:0] free_prns  [MAX_OPERANDS*2],
  output logic [1:0]          retire_count,
  output logic [CNT_BITS-1:0] rob_count,
  output logic                rob_empty
);

  rob_entry_t          entries [ROB_ENTRIES];
  rob_entry_t          new_entry;
  logic [TAG_BITS-1:0] head;
  logic [TAG_BITS-1:0] tail;
  logic [TAG_BITS-1:0] head_next;
  logic [CNT_BITS-1:0] count;
  logic                alloc_fire;
  logic                r0;
  logic                r1;
  logic [1:0]          retire_n;
  logic                next_free_valid [MAX_OPERANDS*2];
  logic [PRN_BITS-1:0] next_free_prns  [MAX_OPERANDS*2];

  assign alloc_ready = (count != CNT_BITS'(ROB_ENTRIES));
  assign alloc_tag   = tail;
  assign rob_count   = count;
  assign rob_empty   = (count == '0);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign head_next   = head + TAG_BITS'(1);
  assign retire_n    = {1'b0, r0} + {1'b0, r1};

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    for (int j = 0; j < int'(MAX_OPERANDS); j++) begin
      new_entry.old_valid[j] = alloc_old_valid[j];
      new_entry.old_prn[j]   = DEFAULT_PRN_BITS'(alloc_old_prn[j]);
    end
  end

  rob_retire_select #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS)
  ) u_retire_select (
    .head_entry      (entries[head]),
    .next_entry      (entries[head_next]),
    .r0              (r0),
    .r1              (r1),
    .next_free_valid (next_free_valid),
    .next_free_prns  (next_free_prns)
  );

  // Later assignments win: retirement clears after completion marks done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROB_ENTRIES); i++) entries[i] <= '0;
    end else begin
      if (complete_valid && entries[complete_tag].valid) entries[complete_tag].done <= 1'b1;
      if (alloc_fire) entries[tail] <= new_entry;
      if (r0) entries[head] <= '0;
      if (r1) entries[head_next] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_count <= '0;
      for (int i = 0; i < int'(MAX_OPERANDS * 2); i++) begin
        free_valid[i] <= 1'b0;
        free_prns[i]  <= '0;
      end
    end else begin
      head         <= head + TAG_BITS'(retire_n);
      tail         <= tail + TAG_BITS'(alloc_fire);
      count        <= count + CNT_BITS'(alloc_fire) - CNT_BITS'(retire_n);
      retire_count <= retire_n;
      for (int i = 0; i < int'(MAX_OPERANDS * 2); i++) begin
        free_valid[i] <= next_free_valid[i];
        free_prns[i]  <= next_free_prns[i];
      end
    end
  end

  // Completing the tag being allocated in the same cycle is an upstream bug.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(complete_valid && alloc_fire && (complete_tag == tail)))
    else $error("reorder_buffer: completion targets the tag being allocated");

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic vs a queue model.
module tb_reorder_buffer;

  localparam int unsigned PB = 6;
  localparam int unsigned MO = 3;
  localparam int unsigned RE = 16;
  localparam int unsigned TB = 4;
  localparam int unsigned CB = 5;
  localparam int unsigned NF = MO * 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_valid;
  logic          alloc_old_valid [MO];
  logic [PB-1:0] alloc_old_prn   [MO];
  logic          alloc_ready;
  logic [TB-1:0] alloc_tag;
  logic          complete_valid;
  logic [TB-1:0] complete_tag;
  logic          free_valid [NF];
  logic [PB-1:0] free_prns  [NF];
  logic [1:0]    retire_count;
  logic [CB-1:0] rob_count;
  logic          rob_empty;
  logic [NF-1:0] fv_vec;

  always #5 clk = ~clk;

  reorder_buffer #(.PRN_BITS(PB), .MAX_OPERANDS(MO), .ROB_ENTRIES(RE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid     (alloc_valid),
    .alloc_old_valid (alloc_old_valid),
    .alloc_old_prn   (alloc_old_prn),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .complete_valid  (complete_valid),
    .complete_tag    (complete_tag),
    .free_valid      (free_valid),
    .free_prns       (free_prns),
    .retire_count    (retire_count),
    .rob_count       (rob_count),
    .rob_empty       (rob_empty)
  );

  always_comb for (int j = 0; j < int'(NF); j++) fv_vec[j] = free_valid[j];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries in program order in a queue of tags.
  bit            m_valid [RE];
  bit            m_done  [RE];
  bit            m_ov    [RE][MO];
  logic [PB-1:0] m_op    [RE][MO];
  int            order[$];
  int            m_tail;
  logic [NF-1:0] e_fv;
  logic [PB-1:0] e_fp [NF];
  int            e_rc;

  task automatic model_reset();
    for (int i = 0; i < int'(RE); i++) begin
      m_valid[i] = 0;
      m_done[i]  = 0;
    end
    order.delete();
    m_tail = 0;
    e_fv   = '0;
    for (int i = 0; i < int'(NF); i++) e_fp[i] = '0;
    e_rc = 0;
  endtask

  task automatic model_update();
    int n;
    int t;
    bit fire;
    fire = alloc_valid && (order.size() < int'(RE));
    n = 0;
    if (order.size() >= 1 && m_done[order[0]]) n = 1;
    if (n == 1 && order.size() >= 2 && m_done[order[1]]) n = 2;
    e_fv = '0;
    for (int i = 0; i < int'(NF); i++) e_fp[i] = '0;
    for (int k = 0; k < n; k++) begin
      t = order[k];
      for (int j = 0; j < int'(MO); j++)
        if (m_ov[t][j]) begin
          e_fv[k*MO+j] = 1'b1;
          e_fp[k*MO+j] = m_op[t][j];
        end
    end
    e_rc = n;
    if (complete_valid && m_valid[complete_tag]) m_done[complete_tag] = 1;
    for (int k = 0; k < n; k++) begin
      t = order.pop_front();
      m_valid[t] = 0;
      m_done[t]  = 0;
    end
    if (fire) begin
      m_valid[m_tail] = 1;
      m_done[m_tail]  = 0;
      for (int j = 0; j < int'(MO); j++) begin
        m_ov[m_tail][j] = alloc_old_valid[j];
        m_op[m_tail][j] = alloc_old_prn[j];
      end
      order.push_back(m_tail);
      m_tail = (m_tail + 1) % int'(RE);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
    complete_tag   = '0;
    for (int j = 0; j < int'(MO); j++) begin
      alloc_old_valid[j] = 1'b0;
      alloc_old_prn[j]   = '0;
    end
  endtask

  task automatic set_alloc(input bit v0, input bit v1, input bit v2,
                           input int p0, input int p1, input int p2);
    alloc_valid        = 1'b1;
    alloc_old_valid[0] = v0;
    alloc_old_valid[1] = v1;
    alloc_old_valid[2] = v2;
    alloc_old_prn[0]   = PB'(p0);
    alloc_old_prn[1]   = PB'(p1);
    alloc_old_prn[2]   = PB'(p2);
  endtask

  task automatic set_complete(input int tag);
    complete_valid = 1'b1;
    complete_tag   = TB'(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    n_checks++;
    if (rob_count !== 5'd0 || alloc_ready !== 1'b1 || rob_empty !== 1'b1 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state count=%0d ready=%b empty=%b tag=%0d want 0/1/1/0",
               rob_count, alloc_ready, rob_empty, alloc_tag);
    end
    n_checks++;
    if (fv_vec !== 6'b0 || retire_count !== 2'd0 || free_prns[0] !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_free fv=%b rc=%0d prn0=%0d want 0", fv_vec, retire_count, free_prns[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    set_alloc(1, 1, 0, 5, 9, 0);
    step();
    idle_inputs();
    n_checks++;
    if (rob_count !== 5'd1 || alloc_tag !== 4'd1 || rob_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_alloc count=%0d tag=%0d empty=%b want 1/1/0", rob_count, alloc_tag, rob_empty);
    end
    set_complete(0);
    step();
    idle_inputs();
    n_checks++;
    if (fv_vec !== 6'b0) begin
      n_fail++;
      $display("FAIL single_early fv=%b want 000000", fv_vec);
    end
    step();
    n_checks++;
    if (fv_vec !== 6'b000011 || free_prns[0] !== 6'd5 || free_prns[1] !== 6'd9 ||
        free_prns[2] !== 6'd0 || retire_count !== 2'd1) begin
      n_fail++;
      $display("FAIL single_free fv=%b p0=%0d p1=%0d p2=%0d rc=%0d want 000011/5/9/0/1",
               fv_vec, free_prns[0], free_prns[1], free_prns[2], retire_count);
    end
    step();
    n_checks++;
    if (fv_vec !== 6'b0 || retire_count !== 2'd0 || rob_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse fv=%b rc=%0d empty=%b want 0/0/1", fv_vec, retire_count, rob_empty);
    end
  endtask

  task automatic test_dual_retire();
    apply_reset();
    set_alloc(1, 0, 0, 3, 0, 0);
    step();
    set_alloc(1, 0, 0, 7, 0, 0);
    step();
    idle_inputs();
    set_complete(1);
    step();
    set_complete(0);
    step();
    idle_inputs();
    n_checks++;
    if (fv_vec !== 6'b0) begin
      n_fail++;
      $display("FAIL dual_hold fv=%b want 000000 (tag1 must wait for tag0)", fv_vec);
    end
    step();
    n_checks++;
    if (fv_vec !== 6'b001001 || free_prns[0] !== 6'd3 || free_prns[3] !== 6'd7 || retire_count !== 2'd2) begin
      n_fail++;
      $display("FAIL dual_free fv=%b p0=%0d p3=%0d rc=%0d want 001001/3/7/2",
               fv_vec, free_prns[0], free_prns[3], retire_count);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < int'(RE); i++) begin
      set_alloc(1, 0, 0, i + 1, 0, 0);
      step();
    end
    n_checks++;
    if (alloc_ready !== 1'b0 || rob_count !== 5'd16 || alloc_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL full_state ready=%b count=%0d tag=%0d want 0/16/0", alloc_ready, rob_count, alloc_tag);
    end
    set_alloc(1, 0, 0, 40, 0, 0);
    step();
    n_checks++;
    if (rob_count !== 5'd16 || alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drop count=%0d ready=%b want 16/0", rob_count, alloc_ready);
    end
    set_complete(0);
    step();
    complete_valid = 1'b0;
    n_checks++;
    if (alloc_ready !== 1'b0 || rob_count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_retire_cycle ready=%b count=%0d want 0/16", alloc_ready, rob_count);
    end
    step();
    n_checks++;
    if (alloc_ready !== 1'b1 || rob_count !== 5'd15 || alloc_tag !== 4'd0 ||
        fv_vec !== 6'b000001 || free_prns[0] !== 6'd1) begin
      n_fail++;
      $display("FAIL full_reopen ready=%b count=%0d tag=%0d fv=%b p0=%0d want 1/15/0/000001/1",
               alloc_ready, rob_count, alloc_tag, fv_vec, free_prns[0]);
    end
    step();
    idle_inputs();
    n_checks++;
    if (rob_count !== 5'd16 || alloc_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL full_wrap count=%0d tag=%0d want 16/1", rob_count, alloc_tag);
    end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1, 0, 0, 10 + i, 0, 0);
      step();
    end
    idle_inputs();
    set_complete(0);
    step();
    set_complete(2);
    step();
    set_complete(3);
    step();
    idle_inputs();
    step();
    n_checks++;
    if (fv_vec !== 6'b0 || retire_count !== 2'd0 || rob_count !== 5'd3) begin
      n_fail++;
      $display("FAIL ooo_blocked fv=%b rc=%0d count=%0d want 0/0/3", fv_vec, retire_count, rob_count);
    end
    set_complete(1);
    step();
    idle_inputs();
    step();
    n_checks++;
    if (fv_vec !== 6'b001001 || free_prns[0] !== 6'd11 || free_prns[3] !== 6'd12 || retire_count !== 2'd2) begin
      n_fail++;
      $display("FAIL ooo_pair fv=%b p0=%0d p3=%0d rc=%0d want 001001/11/12/2",
               fv_vec, free_prns[0], free_prns[3], retire_count);
    end
    step();
    n_checks++;
    if (fv_vec !== 6'b000001 || free_prns[0] !== 6'd13 || retire_count !== 2'd1 || rob_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ooo_last fv=%b p0=%0d rc=%0d empty=%b want 000001/13/1/1",
               fv_vec, free_prns[0], retire_count, rob_empty);
    end
  endtask

  task automatic test_invalid_complete();
    bit seen;
    apply_reset();
    set_alloc(1, 1, 1, 20, 21, 22);
    step();
    idle_inputs();
    set_complete(7);
    step();
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fv_vec !== 6'b0 || retire_count !== 2'd0) seen = 1;
    end
    n_checks++;
    if (seen || rob_count !== 5'd1 || alloc_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL invalid_complete free_seen=%0d count=%0d tag=%0d want 0/1/1", seen, rob_count, alloc_tag);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_alloc(1, 0, 0, 4, 0, 0);
    step();
    set_alloc(1, 0, 0, 8, 0, 0);
    step();
    idle_inputs();
    set_complete(0);
    step();
    idle_inputs();
    step();
    n_checks++;
    if (fv_vec !== 6'b000001 || rob_count !== 5'd1) begin
      n_fail++;
      $display("FAIL midreset_pre fv=%b count=%0d want 000001/1", fv_vec, rob_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rob_count !== 5'd0 || alloc_ready !== 1'b1 || fv_vec !== 6'b0 ||
        retire_count !== 2'd0 || alloc_tag !== 4'd0 || free_prns[0] !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_async count=%0d ready=%b fv=%b rc=%0d tag=%0d p0=%0d want 0/1/0/0/0/0",
               rob_count, alloc_ready, fv_vec, retire_count, alloc_tag, free_prns[0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int pend[$];
    int errs;
    bit fire;
    apply_reset();
    errs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (fv_vec !== e_fv || retire_count !== 2'(e_rc) || rob_count !== CB'(order.size()) ||
          alloc_ready !== (order.size() < int'(RE)) || alloc_tag !== TB'(m_tail) ||
          rob_empty !== (order.size() == 0)) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_state cyc=%0d fv=%b/%b rc=%0d/%0d count=%0d/%0d ready=%b tag=%0d/%0d",
                   cyc, fv_vec, e_fv, retire_count, e_rc, rob_count, order.size(),
                   alloc_ready, alloc_tag, m_tail);
      end
      for (int j = 0; j < int'(NF); j++) begin
        n_checks++;
        if (free_prns[j] !== e_fp[j]) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL rand_prn cyc=%0d idx=%0d got %0d want %0d", cyc, j, free_prns[j], e_fp[j]);
        end
      end
      idle_inputs();
      if ($urandom_range(3) != 0)
        set_alloc(1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(63)));
      pend.delete();
      foreach (order[k]) if (!m_done[order[k]]) pend.push_back(order[k]);
      if (pend.size() > 0 && $urandom_range(1) == 1)
        set_complete(pend[$urandom_range(pend.size() - 1)]);
      else if ($urandom_range(7) == 0)
        set_complete(int'($urandom_range(RE - 1)));
      fire = alloc_valid && (order.size() < int'(RE));
      if (fire && complete_valid && int'(complete_tag) == m_tail) complete_valid = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_retire();
    test_full();
    test_out_of_order();
    test_invalid_complete();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
